// File: rtl/regfile_operand_stage_pkg.sv
// Shared types for the operand-read stage: register addressing and the
// payloads carried on the issue side and toward execute.
package regfile_operand_stage_pkg;

  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned NUM_REGS       = 32;
  // Operand width of the execute payload struct; the top's DATA_WIDTH must not exceed it.
  localparam int unsigned XLEN           = 64;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t rs1;
    reg_addr_t rs2;
    reg_addr_t rd;
    logic      we;
  } issue_payload_t;

  typedef struct packed {
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    reg_addr_t       rd;
    logic            we;
  } ex_payload_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard with RAW/WAW hazard detection.
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   flush                  clear every busy bit next cycle
//   rs1, rs2, rd, we       addresses of the instruction being offered
//   set_en                 instruction accepted and writes rd
//   wb_we, wb_waddr        writeback ports (clear busy, cancel hazards)
//   busy                   registered busy vector
//   rs1/rs2/waw_hazard_c   combinational hazard flags
module regfile_scoreboard
  import regfile_operand_stage_pkg::*;
#(
  parameter int unsigned NR_WB_PORTS   = 2,
  parameter bit          ZERO_REG_ZERO = 1'b1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 flush,
  input  logic [REG_ADDR_WIDTH-1:0]            rs1,
  input  logic [REG_ADDR_WIDTH-1:0]            rs2,
  input  logic [REG_ADDR_WIDTH-1:0]            rd,
  input  logic                                 we,
  input  logic                                 set_en,
  input  logic [NR_WB_PORTS-1:0]               wb_we,
  input  logic [NR_WB_PORTS*REG_ADDR_WIDTH-1:0] wb_waddr,
  output logic [NUM_REGS-1:0]                  busy,
  output logic                                 rs1_hazard_c,
  output logic                                 rs2_hazard_c,
  output logic                                 waw_hazard_c
);

  logic [NUM_REGS-1:0] busy_q, busy_d, wb_hit;

  // One-hot OR of all writeback targets this cycle.
  always_comb begin
    wb_hit = '0;
    for (int unsigned p = 0; p < NR_WB_PORTS; p++) begin
      if (wb_we[p]) wb_hit[wb_waddr[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]] = 1'b1;
    end
  end

  // A writeback landing this cycle is bypassed, so it cancels the hazard.
  assign rs1_hazard_c = busy_q[rs1] && !wb_hit[rs1] && !(ZERO_REG_ZERO && (rs1 == '0));
  assign rs2_hazard_c = busy_q[rs2] && !wb_hit[rs2] && !(ZERO_REG_ZERO && (rs2 == '0));
  assign waw_hazard_c = we && busy_q[rd] && !wb_hit[rd];

  // Clear on writeback, then set on accept so a same-cycle set wins.
  always_comb begin
    busy_d = busy_q & ~wb_hit;
    if (set_en && !(ZERO_REG_ZERO && (rd == '0))) busy_d[rd] = 1'b1;
    if (ZERO_REG_ZERO) busy_d[0] = 1'b0;
    if (flush) busy_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_operand_stage.sv
// Operand-read stage between issue and execute: reads rs1/rs2 from the
// regfile, bypasses same-cycle writebacks, stalls on RAW/WAW via the busy
// scoreboard and registers operands into one output slot.
// Ports:
//   clk_i, rst_ni, flush_i                 clock, async reset, pipeline flush
//   issue_valid_i/ready_o, issue_rs1/rs2/rd/we_i   issue handshake + payload
//   rf_raddr_o {rs2,rs1}, rf_rdata_i {rs2,rs1}     regfile read ports
//   wb_we_i, wb_waddr_i, wb_wdata_i        writeback ports (bypass + clear)
//   ex_valid_o/ready_i, ex_op_a/b_o, ex_rd_o, ex_we_o   execute slot
//   busy_o                                 scoreboard state
module regfile_operand_stage
  import regfile_operand_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned NR_WB_PORTS   = 2,
  parameter bit          ZERO_REG_ZERO = 1'b1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  flush_i,
  input  logic                                  issue_valid_i,
  output logic                                  issue_ready_o,
  input  logic [REG_ADDR_WIDTH-1:0]             issue_rs1_i,
  input  logic [REG_ADDR_WIDTH-1:0]             issue_rs2_i,
  input  logic [REG_ADDR_WIDTH-1:0]             issue_rd_i,
  input  logic                                  issue_we_i,
  output logic [2*REG_ADDR_WIDTH-1:0]           rf_raddr_o,
  input  logic [2*DATA_WIDTH-1:0]               rf_rdata_i,
  input  logic [NR_WB_PORTS-1:0]                wb_we_i,
  input  logic [NR_WB_PORTS*REG_ADDR_WIDTH-1:0] wb_waddr_i,
  input  logic [NR_WB_PORTS*DATA_WIDTH-1:0]     wb_wdata_i,
  output logic                                  ex_valid_o,
  input  logic                                  ex_ready_i,
  output logic [DATA_WIDTH-1:0]                 ex_op_a_o,
  output logic [DATA_WIDTH-1:0]                 ex_op_b_o,
  output logic [REG_ADDR_WIDTH-1:0]             ex_rd_o,
  output logic                                  ex_we_o,
  output logic [NUM_REGS-1:0]                   busy_o
);

  issue_payload_t  iss;
  ex_payload_t     ex_q, ex_d;
  logic            ex_valid_q, ex_valid_d;
  logic            rs1_hz, rs2_hz, waw_hz;
  logic            slot_free, accept;
  logic [DATA_WIDTH-1:0] op_a, op_b;

  assign iss = '{rs1: issue_rs1_i, rs2: issue_rs2_i, rd: issue_rd_i, we: issue_we_i};

  assign rf_raddr_o = {iss.rs2, iss.rs1};

  regfile_scoreboard #(
    .NR_WB_PORTS  (NR_WB_PORTS),
    .ZERO_REG_ZERO(ZERO_REG_ZERO)
  ) i_scoreboard (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush       (flush_i),
    .rs1         (iss.rs1),
    .rs2         (iss.rs2),
    .rd          (iss.rd),
    .we          (iss.we),
    .set_en      (accept && iss.we),
    .wb_we       (wb_we_i),
    .wb_waddr    (wb_waddr_i),
    .busy        (busy_o),
    .rs1_hazard_c(rs1_hz),
    .rs2_hazard_c(rs2_hz),
    .waw_hazard_c(waw_hz)
  );

  assign slot_free     = !ex_valid_q || ex_ready_i;
  assign issue_ready_o = slot_free && !flush_i && !rs1_hz && !rs2_hz && !waw_hz;
  assign accept        = issue_valid_i && issue_ready_o;

  // x0 forces zero; otherwise the highest-index hitting writeback port wins,
  // mirroring the regfile's write priority.
  function automatic logic [DATA_WIDTH-1:0] sel_operand(
    input reg_addr_t             addr,
    input logic [DATA_WIDTH-1:0] rf_data
  );
    logic [DATA_WIDTH-1:0] res;
    res = rf_data;
    for (int unsigned p = 0; p < NR_WB_PORTS; p++) begin
      if (wb_we_i[p] && (wb_waddr_i[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == addr))
        res = wb_wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
    end
    if (ZERO_REG_ZERO && (addr == '0)) res = '0;
    return res;
  endfunction

  assign op_a = sel_operand(iss.rs1, rf_rdata_i[DATA_WIDTH-1:0]);
  assign op_b = sel_operand(iss.rs2, rf_rdata_i[2*DATA_WIDTH-1:DATA_WIDTH]);

  // Output slot: flush kills, accept loads, consume empties, otherwise hold.
  always_comb begin
    ex_d       = ex_q;
    ex_valid_d = ex_valid_q;
    if (flush_i) begin
      ex_valid_d = 1'b0;
    end else if (accept) begin
      ex_valid_d = 1'b1;
      ex_d       = '{op_a: XLEN'(op_a), op_b: XLEN'(op_b), rd: iss.rd, we: iss.we};
    end else if (ex_ready_i) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
    end else begin
      ex_q       <= ex_d;
      ex_valid_q <= ex_valid_d;
    end
  end

  assign ex_valid_o = ex_valid_q;
  assign ex_op_a_o  = DATA_WIDTH'(ex_q.op_a);
  assign ex_op_b_o  = DATA_WIDTH'(ex_q.op_b);
  assign ex_rd_o    = ex_q.rd;
  assign ex_we_o    = ex_q.we;

endmodule
